rv_muldiv_iter: RTL and testbench
=================================

Name: rv_muldiv_iter

Overview:
- Parametrised, multi-cycle RV-M execution unit implementing MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the single-cycle ALU in the execute stage and takes ops decoded with opcode 0110011 and funct7 = 0x01.
- Uses an iterative radix-2 shift-add multiplier and a restoring divider, with valid/ready handshakes on both sides.
- Corrects the high-word, unsigned and remainder semantics to match the RISC-V M spec exactly, including divide-by-zero and overflow.

Parameters:
- XLEN, 32, operand and result width; any even value ≥ 8.
- TAG_W, 5, width of the opaque tag carried with each op (normally the rd index).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort of any in-flight op.
- in_valid  in  1  op request.
- in_ready  out  1  unit can accept an op.
- funct3  in  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1  in  XLEN  operand A.
- rs2  in  XLEN  operand B.
- tag_in  in  TAG_W  tag, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- rd  out  XLEN  result.
- tag_out  out  TAG_W  tag of the result.
- busy  out  1  state ≠ IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; out_valid = 0; rd = 0; tag_out = 0; busy = 0.
  - All internal registers are cleared.
  - Reset mid-operation discards the op with no output.
- States:
  - IDLE: in_ready = 1.
  - CALC: iterating; in_ready = 0.
  - DONE: out_valid = 1; in_ready = out_ready.
- Accept:
  - An op is accepted on an edge where in_valid & in_ready.
  - funct3, tag and operand magnitudes are latched at that edge.
  - Signedness: rs1 is signed for MULH, MULHSU, DIV and REM. rs2 is signed for MULH, DIV and REM. MUL is sign-agnostic and is treated as unsigned.
  - Negative operands are converted to magnitudes.
  - Result sign is stored: product and quotient sign = sa ^ sb; remainder sign = sign of the dividend.
- Special cases (DIV-class ops only), detected at accept. The op goes directly to DONE on the next edge (latency 1), skipping CALC:
  - rs2 == 0: quotient = all ones; remainder = rs1.
  - DIV/REM with rs1 = most-negative and rs2 = −1: quotient = rs1; remainder = 0.
- CALC:
  - A counter runs 0..XLEN-1, performing one iteration per edge.
  - MUL-class: 2·XLEN accumulator; shift-add one multiplier bit per cycle.
  - DIV-class: restoring shift-subtract; one quotient bit per cycle.
  - On the edge where counter = XLEN-1, the final sign correction is applied (two's complement over 2·XLEN bits for products). rd is then loaded with the selected half: low for MUL, high for MULH*, quotient or remainder for division. State moves to DONE.
  - Latency from the accept edge to out_valid is exactly XLEN cycles.
- DONE:
  - rd and tag_out are held stable until out_ready.
  - On out_ready without a new op: go to IDLE.
  - If in_valid is also high on that edge, accept the new op: go to CALC, or to DONE for a special case. out_valid is not dropped in the special-case path, and rd updates.
- flush:
  - Forces state = IDLE and out_valid = 0 on the next edge, from any state.
  - flush has priority over accept; in_ready is forced to 0 while flush = 1.
- Result width: all arithmetic is on unsigned magnitudes. Truncation to XLEN happens only at the rd load.

Decomposition:
- rv_muldiv_pkg:
  - funct3 enum muldiv_op_e (MUL…REMU).
  - state enum muldiv_state_e {IDLE, CALC, DONE}.
  - Helper functions is_div(op), op_a_signed(op), op_b_signed(op).
- No sub-module: the shift-add and shift-subtract steps share one XLEN+1-bit adder inline.

Test Plan:
- XLEN=32, MUL rs1=7, rs2=0xFFFFFFFD -> rd=0xFFFFFFEB; out_valid exactly 32 cycles after the accept edge; tag_out = tag_in.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD; REM −7,2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100,7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5,0 -> 5, each out_valid 1 cycle after accept. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- out_ready held low 5 cycles in DONE -> rd/out_valid stable and in_ready = 0. Then out_ready = 1 with in_valid = 1 -> back-to-back accept, no idle cycle.
- flush at CALC cycle 10 -> IDLE next edge, no out_valid. rst_n low mid-CALC -> all outputs 0 immediately; the next op completes correctly.

Source files
------------

// File: rtl/rv_muldiv_pkg.sv
// rv_muldiv_pkg
// Shared types and decode helpers for the iterative RV-M multiply/divide unit.
//   muldiv_op_e    : funct3 encoding of the eight M-extension ops
//   muldiv_state_e : controller states
//   muldiv_ctx_t   : per-op context latched at accept
//   is_div / is_rem / op_a_signed / op_b_signed : funct3 decode helpers
package rv_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // Context kept for the whole op: which result to select and how to
    // fix up the sign of the unsigned-magnitude result.
    typedef struct packed {
        muldiv_op_e op;
        logic       neg_q;   // negate product / quotient
        logic       neg_r;   // negate remainder
    } muldiv_ctx_t;

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    // MUL only keeps the low word, which is the same for any signedness,
    // so it is handled as unsigned.
    function automatic logic op_a_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/rv_muldiv_iter.sv
// rv_muldiv_iter
// Multi-cycle RV-M execution unit: radix-2 shift-add multiplier and
// restoring divider sharing one adder and one 2*XLEN working register.
// Operands are reduced to magnitudes at accept; the result sign is fixed
// up on the final iteration.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             synchronous abort of any in-flight op
//   in_valid/in_ready op request handshake (funct3, rs1, rs2, tag_in)
//   out_valid/out_ready result handshake (rd, tag_out)
//   busy              controller not idle
module rv_muldiv_iter
    import rv_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  rd,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state;
    logic [CNT_W-1:0]  cnt;
    // MUL: {partial sum, multiplier}.  DIV: {partial remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   b_mag;
    muldiv_ctx_t       ctx;
    logic [TAG_W-1:0]  tag_q;

    // ---------------- accept-side decode ----------------
    muldiv_op_e       op_in;
    logic             sa, sb, accept, div_zero, div_ovf;
    logic [XLEN-1:0]  a_mag_in, b_mag_in, special_rd;

    assign op_in    = muldiv_op_e'(funct3);
    assign sa       = op_a_signed(op_in) & rs1[XLEN-1];
    assign sb       = op_b_signed(op_in) & rs2[XLEN-1];
    assign a_mag_in = sa ? -rs1 : rs1;
    assign b_mag_in = sb ? -rs2 : rs2;

    assign div_zero = is_div(op_in) && (rs2 == '0);
    assign div_ovf  = is_div(op_in) && op_a_signed(op_in) &&
                      (rs1 == MIN_NEG) && (rs2 == '1);

    always_comb begin
        special_rd = '0;
        if (div_zero)
            special_rd = is_rem(op_in) ? rs1 : '1;
        else
            special_rd = is_rem(op_in) ? '0 : rs1;
    end

    assign in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // ---------------- shared iteration datapath ----------------
    // MUL adds the multiplicand when the multiplier LSB is set.
    // DIV subtracts the divisor from {rem, next dividend bit} via a + ~b + 1;
    // the carry out means no borrow, i.e. the quotient bit is 1.
    logic [XLEN:0]     add_a, add_b;
    logic              add_cin;
    logic [XLEN+1:0]   add_sum;
    logic [2*XLEN-1:0] acc_step;
    logic              no_borrow;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (is_div(ctx.op)) begin
            add_a   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
            add_b   = ~{1'b0, b_mag};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, acc[2*XLEN-1:XLEN]};
            add_b   = acc[0] ? {1'b0, b_mag} : '0;
        end
    end

    assign add_sum   = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, add_cin};
    assign no_borrow = add_sum[XLEN+1];

    always_comb begin
        acc_step = '0;
        if (is_div(ctx.op)) begin
            // Restored remainder always fits XLEN bits since it stays below the divisor.
            acc_step = {(no_borrow ? add_sum[XLEN-1:0] : add_a[XLEN-1:0]),
                        acc[XLEN-2:0], no_borrow};
        end else begin
            acc_step = {add_sum[XLEN:0], acc[XLEN-1:1]};
        end
    end

    // ---------------- sign correction and result select ----------------
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, final_rd;

    assign prod = ctx.neg_q ? -acc_step : acc_step;
    assign quo  = ctx.neg_q ? -acc_step[XLEN-1:0]      : acc_step[XLEN-1:0];
    assign rem  = ctx.neg_r ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

    always_comb begin
        final_rd = '0;
        unique case (ctx.op)
            OP_MUL:                        final_rd = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_rd = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_rd = quo;
            OP_REM, OP_REMU:               final_rd = rem;
            default:                       final_rd = '0;
        endcase
    end

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            b_mag   <= '0;
            ctx     <= '0;
            tag_q   <= '0;
            rd      <= '0;
            tag_out <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else if (accept) begin
            ctx.op    <= op_in;
            ctx.neg_q <= sa ^ sb;
            ctx.neg_r <= sa;
            tag_q     <= tag_in;
            acc       <= {{XLEN{1'b0}}, a_mag_in};
            b_mag     <= b_mag_in;
            cnt       <= '0;
            if (div_zero || div_ovf) begin
                // Result is known without iterating; out_valid stays up
                // when this is a back-to-back accept from DONE.
                rd      <= special_rd;
                tag_out <= tag_in;
                state   <= DONE;
            end else begin
                state <= CALC;
            end
        end else begin
            unique case (state)
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        rd      <= final_rd;
                        tag_out <= tag_q;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_muldiv_iter.sv
// Directed bench for rv_muldiv_iter (XLEN=32). Stimulus pushes the
// hand-computed result into a queue at the accept edge; a monitor pops and
// compares on every output handshake. The latency field is the number of
// clock edges between the accept edge and the edge that raises out_valid:
// XLEN for iterated ops, 0 for divide-by-zero / overflow (out_valid is then
// high in the very first cycle after accept).
module tb_rv_muldiv_iter;
    import rv_muldiv_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  rs1, rs2, rd;
    logic [TAG_W-1:0] tag_in, tag_out;

    rv_muldiv_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd(rd), .tag_out(tag_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0]  rd;
        logic [TAG_W-1:0] tag;
        int               acc_cyc;
        int               lat;     // -1: not checked
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    // Called just after a rising edge. Returns just after the accept edge.
    task automatic issue(input muldiv_op_e f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] t, input logic [XLEN-1:0] want,
                         input int lat, input bit push);
        int n;
        exp_t e;
        funct3 = f; rs1 = a; rs2 = b; tag_in = t; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL accept_timeout op=%0d tag=%0d", f, t);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (push) begin
                e.rd = want; e.tag = t; e.acc_cyc = cyc; e.lat = lat;
                q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout pending=%0d busy=%0b", q.size(), busy);
        end
    endtask

    // Monitor: one pop per output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output rd=%h tag=%0d", rd, tag_out);
                end else begin
                    e = q.pop_front();
                    if (rd !== e.rd || tag_out !== e.tag) begin
                        errors++;
                        $display("FAIL result tag=%0d got rd=%h tag=%0d want rd=%h tag=%0d",
                                 e.tag, rd, tag_out, e.rd, e.tag);
                    end
                    if (e.lat >= 0) begin
                        checks++;
                        if (cyc - e.acc_cyc != e.lat) begin
                            errors++;
                            $display("FAIL latency tag=%0d got %0d want %0d",
                                     e.tag, cyc - e.acc_cyc, e.lat);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        funct3 = '0; rs1 = '0; rs2 = '0; tag_in = '0;

        repeat (3) @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_rd", rd, 32'd0);
        chk("reset_tag_out", {27'd0, tag_out}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Multiplies
        issue(OP_MUL,    32'd7,        32'hFFFFFFFD, 5'h0A, 32'hFFFFFFEB, XLEN, 1'b1);
        issue(OP_MULH,   32'h80000000, 32'h80000000, 5'h01, 32'h40000000, XLEN, 1'b1);
        issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'h02, 32'hFFFFFFFE, XLEN, 1'b1);
        issue(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h03, 32'hFFFFFFFF, XLEN, 1'b1);
        // Divides
        issue(OP_DIV,    32'hFFFFFFF9, 32'd2,        5'h04, 32'hFFFFFFFD, XLEN, 1'b1);
        issue(OP_REM,    32'hFFFFFFF9, 32'd2,        5'h05, 32'hFFFFFFFF, XLEN, 1'b1);
        issue(OP_DIVU,   32'd100,      32'd7,        5'h06, 32'd14,       XLEN, 1'b1);
        issue(OP_REMU,   32'd100,      32'd7,        5'h07, 32'd2,        XLEN, 1'b1);
        issue(OP_DIV,    32'd7,        32'hFFFFFFFE, 5'h08, 32'hFFFFFFFD, XLEN, 1'b1);
        issue(OP_REM,    32'd7,        32'hFFFFFFFE, 5'h09, 32'd1,        XLEN, 1'b1);
        // Special cases, including back-to-back from DONE
        issue(OP_DIVU,   32'd5,        32'd0,        5'h0B, 32'hFFFFFFFF, 0, 1'b1);
        issue(OP_REMU,   32'd5,        32'd0,        5'h0C, 32'd5,        0, 1'b1);
        issue(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'h0D, 32'h80000000, 0, 1'b1);
        issue(OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'h0E, 32'd0,        0, 1'b1);
        drain();

        // Output stall: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(OP_MUL, 32'd3, 32'd4, 5'h03, 32'd12, -1, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL stall_wait_timeout out_valid=%0b", out_valid);
        end
        repeat (5) begin
            @(negedge clk);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_rd", rd, 32'd12);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        issue(OP_DIVU, 32'd100, 32'd7, 5'h04, 32'd14, XLEN, 1'b1);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_out_valid", {31'd0, out_valid}, 32'd0);
        drain();

        // Flush mid-CALC: no output may appear.
        issue(OP_MUL, 32'd5, 32'd6, 5'h10, 32'd30, -1, 1'b0);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("flush_no_output", bad, 32'd0);
        @(posedge clk); #1;

        // Async reset mid-CALC; rd holds 14 from the last completed op.
        issue(OP_MUL, 32'd9, 32'd9, 5'h11, 32'd81, -1, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_rd", rd, 32'd0);
        chk("rst_mid_tag_out", {27'd0, tag_out}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h07, 32'hFFFFFFFE, XLEN, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
